// File: rtl/control_multi_hs.sv
// Multicycle RV32I main-control FSM with a memory ready handshake.
// Adds a wait-state timeout, an illegal-opcode trap and a per-instruction retire pulse.
module control_multi_hs #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic [6:0] iOp,
  input  logic       iMemReady,
  output logic       oIRWrite,
  output logic       oPCWrite,
  output logic       oPCCondWrite,
  output logic       oIorD,
  output logic       oMemRead,
  output logic       oMemWrite,
  output logic       oRegWrite,
  output logic [1:0] oMem2Reg,
  output logic [1:0] oALUOp,
  output logic [1:0] oOrigAALU,
  output logic [1:0] oOrigBALU,
  output logic [1:0] oOrigPC,
  output logic       oRetire,
  output logic       oTrap,
  output logic [1:0] oTrapCause,
  output logic [2:0] oState
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  state_t           state_reg;
  logic [CNT_W-1:0] wait_cnt_reg;
  logic [1:0]       cause_reg;

  logic op_legal;
  logic in_access;
  logic timeout_hit;

  always_comb begin
    case (iOp)
      OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: op_legal = 1'b1;
      default:                           op_legal = 1'b0;
    endcase
  end

  assign in_access   = (state_reg == S_FETCH) || (state_reg == S_MEM);
  // A ready on the last allowed cycle still completes the access.
  assign timeout_hit = (TIMEOUT != 0) && in_access && !iMemReady &&
                       (wait_cnt_reg == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_reg    <= S_FETCH;
      wait_cnt_reg <= '0;
      cause_reg    <= 2'b00;
    end else begin
      if (!in_access) begin
        wait_cnt_reg <= '0;
      end
      case (state_reg)
        S_FETCH, S_MEM: begin
          if (iMemReady) begin
            wait_cnt_reg <= '0;
            if (state_reg == S_FETCH) begin
              state_reg <= S_DECODE;
            end else if (iOp == OP_LOAD) begin
              state_reg <= S_WB;
            end else begin
              state_reg <= S_FETCH;
            end
          end else if (timeout_hit) begin
            state_reg <= S_TRAP;
            cause_reg <= CAUSE_TIMEOUT;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
          end
        end
        S_DECODE: begin
          if (op_legal) begin
            state_reg <= S_EXE;
          end else begin
            state_reg <= S_TRAP;
            cause_reg <= CAUSE_ILLEGAL;
          end
        end
        S_EXE: begin
          case (iOp)
            OP_LOAD, OP_STORE:                state_reg <= S_MEM;
            OP_R, OP_I, OP_LUI, OP_AUIPC:     state_reg <= S_WB;
            OP_BRANCH, OP_JAL, OP_JALR:       state_reg <= S_FETCH;
            default: begin
              state_reg <= S_TRAP;
              cause_reg <= CAUSE_ILLEGAL;
            end
          endcase
        end
        S_WB:    state_reg <= S_FETCH;
        S_TRAP:  state_reg <= S_TRAP;
        default: state_reg <= S_FETCH;
      endcase
    end
  end

  // While iRST is high every enable and request is forced low, so an access
  // in flight is abandoned immediately rather than at the next edge.
  always_comb begin
    oIRWrite     = 1'b0;
    oPCWrite     = 1'b0;
    oPCCondWrite = 1'b0;
    oIorD        = 1'b0;
    oMemRead     = 1'b0;
    oMemWrite    = 1'b0;
    oRegWrite    = 1'b0;
    oMem2Reg     = 2'b00;
    oALUOp       = 2'b00;
    oOrigAALU    = 2'b00;
    oOrigBALU    = 2'b00;
    oOrigPC      = 2'b00;
    oRetire      = 1'b0;
    oTrap        = (state_reg == S_TRAP);
    oTrapCause   = cause_reg;
    oState       = state_reg;
    if (!iRST) begin
      case (state_reg)
        S_FETCH: begin
          oMemRead  = 1'b1;
          oOrigAALU = 2'b11;
          oOrigBALU = 2'b01;
          if (iMemReady) begin
            oIRWrite = 1'b1;
            oPCWrite = 1'b1;
          end
        end
        S_DECODE: begin
          oOrigAALU = 2'b00;
          oOrigBALU = 2'b10;
        end
        S_EXE: begin
          case (iOp)
            OP_LOAD, OP_STORE: begin
              oOrigAALU = 2'b01;
              oOrigBALU = 2'b10;
            end
            OP_R: begin
              oOrigAALU = 2'b01;
              oOrigBALU = 2'b00;
              oALUOp    = 2'b10;
            end
            OP_I: begin
              oOrigAALU = 2'b01;
              oOrigBALU = 2'b10;
              oALUOp    = 2'b10;
            end
            OP_LUI: begin
              oOrigAALU = 2'b10;
              oOrigBALU = 2'b10;
            end
            OP_AUIPC: begin
              oOrigAALU = 2'b00;
              oOrigBALU = 2'b10;
            end
            OP_BRANCH: begin
              oOrigAALU    = 2'b01;
              oOrigBALU    = 2'b00;
              oALUOp       = 2'b01;
              oPCCondWrite = 1'b1;
              oOrigPC      = 2'b01;
              oRetire      = 1'b1;
            end
            OP_JAL: begin
              oRegWrite = 1'b1;
              oMem2Reg  = 2'b10;
              oPCWrite  = 1'b1;
              oOrigPC   = 2'b01;
              oRetire   = 1'b1;
            end
            OP_JALR: begin
              oOrigAALU = 2'b01;
              oOrigBALU = 2'b10;
              oRegWrite = 1'b1;
              oMem2Reg  = 2'b10;
              oPCWrite  = 1'b1;
              oOrigPC   = 2'b10;
              oRetire   = 1'b1;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          oIorD     = 1'b1;
          oMemRead  = (iOp == OP_LOAD);
          oMemWrite = (iOp == OP_STORE);
          oRetire   = iMemReady && (iOp == OP_STORE);
        end
        S_WB: begin
          oRegWrite = 1'b1;
          oMem2Reg  = (iOp == OP_LOAD) ? 2'b01 : 2'b00;
          oRetire   = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_multi_hs.sv
// Randomized bench for control_multi_hs: an instruction-level model expands each
// opcode and wait pattern into the expected per-cycle control words.
module tb_control_multi_hs;

  localparam int TO = 4;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic       pc_cond_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] mem2reg;
    logic [1:0] alu_op;
    logic [1:0] a_sel;
    logic [1:0] b_sel;
    logic [1:0] pc_sel;
    logic       retire;
    logic       trap;
    logic [1:0] cause;
    logic [2:0] state;
  } ctrl_t;

  logic       iCLK;
  logic       iRST;
  logic [6:0] iOp;
  logic       iMemReady;
  logic       oIRWrite, oPCWrite, oPCCondWrite, oIorD, oMemRead, oMemWrite, oRegWrite;
  logic [1:0] oMem2Reg, oALUOp, oOrigAALU, oOrigBALU, oOrigPC;
  logic       oRetire, oTrap;
  logic [1:0] oTrapCause;
  logic [2:0] oState;

  int total = 0;
  int bad   = 0;

  logic [6:0] legal_ops [9] = '{OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH,
                                 OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};

  logic [6:0] stim_op_q [$];
  logic       stim_rdy_q[$];
  ctrl_t      exp_q     [$];
  ctrl_t      obs_q     [$];

  control_multi_hs #(.TIMEOUT(TO), .CNT_W(3)) dut (
    .iCLK(iCLK), .iRST(iRST), .iOp(iOp), .iMemReady(iMemReady),
    .oIRWrite(oIRWrite), .oPCWrite(oPCWrite), .oPCCondWrite(oPCCondWrite),
    .oIorD(oIorD), .oMemRead(oMemRead), .oMemWrite(oMemWrite), .oRegWrite(oRegWrite),
    .oMem2Reg(oMem2Reg), .oALUOp(oALUOp), .oOrigAALU(oOrigAALU), .oOrigBALU(oOrigBALU),
    .oOrigPC(oOrigPC), .oRetire(oRetire), .oTrap(oTrap), .oTrapCause(oTrapCause),
    .oState(oState)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic ctrl_t observe();
    ctrl_t c;
    c.ir_write      = oIRWrite;
    c.pc_write      = oPCWrite;
    c.pc_cond_write = oPCCondWrite;
    c.iord          = oIorD;
    c.mem_read      = oMemRead;
    c.mem_write     = oMemWrite;
    c.reg_write     = oRegWrite;
    c.mem2reg       = oMem2Reg;
    c.alu_op        = oALUOp;
    c.a_sel         = oOrigAALU;
    c.b_sel         = oOrigBALU;
    c.pc_sel        = oOrigPC;
    c.retire        = oRetire;
    c.trap          = oTrap;
    c.cause         = oTrapCause;
    c.state         = oState;
    return c;
  endfunction

  function automatic bit is_legal(input logic [6:0] op);
    for (int i = 0; i < 9; i++) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [6:0] random_illegal();
    logic [6:0] op;
    op = 7'($urandom);
    while (is_legal(op)) op = 7'($urandom);
    return op;
  endfunction

  // ---------------- reference model ----------------
  task automatic clear_model();
    stim_op_q.delete();
    stim_rdy_q.delete();
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic push(input logic [6:0] op, input logic rdy, input ctrl_t c);
    stim_op_q.push_back(op);
    stim_rdy_q.push_back(rdy);
    exp_q.push_back(c);
  endtask

  task automatic push_trap(input logic [1:0] cause);
    ctrl_t c;
    c = '0;
    c.trap  = 1'b1;
    c.cause = cause;
    c.state = 3'd7;
    for (int i = 0; i < 3; i++) push(7'($urandom), 1'($urandom), c);
  endtask

  // Expected cycles of one instruction: fw/mw are the not-ready cycles before
  // the fetch/memory access completes; TO or more means the access never completes.
  task automatic model_instr(input logic [6:0] op, input int fw, input int mw,
                             output bit trapped);
    ctrl_t c;
    bit    is_ld, is_st;
    trapped = 1'b0;
    is_ld = (op == OP_LOAD);
    is_st = (op == OP_STORE);

    c = '0;
    c.mem_read = 1'b1;
    c.a_sel    = 2'b11;
    c.b_sel    = 2'b01;
    c.state    = 3'd0;
    for (int i = 0; i < fw && i < TO; i++) push(7'($urandom), 1'b0, c);
    if (fw >= TO) begin
      push_trap(2'b10);
      trapped = 1'b1;
      return;
    end
    c.ir_write = 1'b1;
    c.pc_write = 1'b1;
    push(7'($urandom), 1'b1, c);

    c = '0;
    c.a_sel = 2'b00;
    c.b_sel = 2'b10;
    c.state = 3'd1;
    push(op, 1'($urandom), c);
    if (!is_legal(op)) begin
      push_trap(2'b01);
      trapped = 1'b1;
      return;
    end

    c = '0;
    c.state = 3'd2;
    if (is_ld || is_st)     begin c.a_sel = 2'b01; c.b_sel = 2'b10; end
    else if (op == OP_R)    begin c.a_sel = 2'b01; c.b_sel = 2'b00; c.alu_op = 2'b10; end
    else if (op == OP_I)    begin c.a_sel = 2'b01; c.b_sel = 2'b10; c.alu_op = 2'b10; end
    else if (op == OP_LUI)  begin c.a_sel = 2'b10; c.b_sel = 2'b10; end
    else if (op == OP_AUIPC) begin c.a_sel = 2'b00; c.b_sel = 2'b10; end
    else if (op == OP_BRANCH) begin
      c.a_sel = 2'b01; c.b_sel = 2'b00; c.alu_op = 2'b01;
      c.pc_cond_write = 1'b1; c.pc_sel = 2'b01; c.retire = 1'b1;
    end else if (op == OP_JAL) begin
      c.reg_write = 1'b1; c.mem2reg = 2'b10; c.pc_write = 1'b1;
      c.pc_sel = 2'b01; c.retire = 1'b1;
    end else begin
      c.a_sel = 2'b01; c.b_sel = 2'b10;
      c.reg_write = 1'b1; c.mem2reg = 2'b10; c.pc_write = 1'b1;
      c.pc_sel = 2'b10; c.retire = 1'b1;
    end
    push(op, 1'($urandom), c);
    if (op == OP_BRANCH || op == OP_JAL || op == OP_JALR) return;

    if (is_ld || is_st) begin
      c = '0;
      c.iord      = 1'b1;
      c.mem_read  = is_ld;
      c.mem_write = is_st;
      c.state     = 3'd3;
      for (int i = 0; i < mw && i < TO; i++) push(op, 1'b0, c);
      if (mw >= TO) begin
        push_trap(2'b10);
        trapped = 1'b1;
        return;
      end
      c.retire = is_st;
      push(op, 1'b1, c);
      if (is_st) return;
    end

    c = '0;
    c.reg_write = 1'b1;
    c.mem2reg   = is_ld ? 2'b01 : 2'b00;
    c.retire    = 1'b1;
    c.state     = 3'd4;
    push(op, 1'($urandom), c);
  endtask

  // ---------------- stimulus driver (starts and ends just after a negedge) ----------------
  task automatic run_trace();
    obs_q.delete();
    for (int k = 0; k < stim_rdy_q.size(); k++) begin
      iOp       = stim_op_q[k];
      iMemReady = stim_rdy_q[k];
      #1;
      obs_q.push_back(observe());
      @(negedge iCLK);
    end
  endtask

  task automatic do_reset();
    iRST      = 1'b1;
    iMemReady = 1'b0;
    @(negedge iCLK);
    iRST = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    ctrl_t z, f;
    @(negedge iCLK);
    iRST      = 1'b1;
    iMemReady = 1'b1;
    iOp       = 7'($urandom);
    #1;
    z = '0;
    total++;
    if (observe() !== z) begin
      bad++;
      $display("FAIL reset_hold got=%h exp=%h", observe(), z);
    end
    @(negedge iCLK);
    iRST      = 1'b0;
    iMemReady = 1'b0;
    #1;
    f = '0;
    f.mem_read = 1'b1;
    f.a_sel    = 2'b11;
    f.b_sel    = 2'b01;
    total++;
    if (observe() !== f) begin
      bad++;
      $display("FAIL reset_release got=%h exp=%h", observe(), f);
    end
    $display("txn reset: hold and release checked");
    @(negedge iCLK);
    do_reset();
  endtask

  task automatic test_add();
    bit tr;
    int first_ret;
    clear_model();
    model_instr(OP_R, 0, 0, tr);
    run_trace();
    for (int k = 0; k < exp_q.size(); k++) begin
      total++;
      if (obs_q[k] !== exp_q[k]) begin
        bad++;
        $display("FAIL add cyc=%0d got=%h exp=%h", k, obs_q[k], exp_q[k]);
      end
    end
    first_ret = -1;
    for (int k = obs_q.size() - 1; k >= 0; k--) if (obs_q[k].retire) first_ret = k;
    total++;
    if (first_ret != 3) begin
      bad++;
      $display("FAIL add_retire_cycle got=%0d exp=3", first_ret);
    end
    $display("txn add: cycles=%0d", exp_q.size());
  endtask

  task automatic test_lw_wait();
    bit tr;
    int reads;
    clear_model();
    model_instr(OP_LOAD, 0, 3, tr);
    run_trace();
    reads = 0;
    for (int k = 0; k < exp_q.size(); k++) begin
      total++;
      if (obs_q[k] !== exp_q[k]) begin
        bad++;
        $display("FAIL lw_wait cyc=%0d got=%h exp=%h", k, obs_q[k], exp_q[k]);
      end
      if (obs_q[k].state == 3'd3 && obs_q[k].mem_read) reads++;
    end
    total++;
    if (reads != 4) begin
      bad++;
      $display("FAIL lw_memread_cycles got=%0d exp=4", reads);
    end
    $display("txn lw_wait: cycles=%0d", exp_q.size());
  endtask

  task automatic test_sw_timeout();
    bit tr;
    int writes;
    clear_model();
    model_instr(OP_STORE, 0, 99, tr);
    run_trace();
    writes = 0;
    for (int k = 0; k < exp_q.size(); k++) begin
      total++;
      if (obs_q[k] !== exp_q[k]) begin
        bad++;
        $display("FAIL sw_timeout cyc=%0d got=%h exp=%h", k, obs_q[k], exp_q[k]);
      end
      if (obs_q[k].mem_write) writes++;
    end
    total++;
    if (writes != TO) begin
      bad++;
      $display("FAIL sw_memwrite_cycles got=%0d exp=%0d", writes, TO);
    end
    $display("txn sw_timeout: cycles=%0d", exp_q.size());
    do_reset();
  endtask

  task automatic test_illegal();
    bit tr;
    clear_model();
    model_instr(7'b0000000, 1, 0, tr);
    run_trace();
    for (int k = 0; k < exp_q.size(); k++) begin
      total++;
      if (obs_q[k] !== exp_q[k]) begin
        bad++;
        $display("FAIL illegal cyc=%0d got=%h exp=%h", k, obs_q[k], exp_q[k]);
      end
    end
    $display("txn illegal: cycles=%0d", exp_q.size());
    do_reset();
  endtask

  task automatic test_jalr();
    bit tr;
    clear_model();
    model_instr(OP_JALR, 2, 0, tr);
    run_trace();
    for (int k = 0; k < exp_q.size(); k++) begin
      total++;
      if (obs_q[k] !== exp_q[k]) begin
        bad++;
        $display("FAIL jalr cyc=%0d got=%h exp=%h", k, obs_q[k], exp_q[k]);
      end
    end
    $display("txn jalr: cycles=%0d", exp_q.size());
  endtask

  task automatic test_reset_mid_fetch();
    ctrl_t z;
    bit tr;
    iOp       = 7'($urandom);
    iMemReady = 1'b0;
    @(negedge iCLK);
    @(negedge iCLK);
    #2;
    iRST      = 1'b1;
    iMemReady = 1'b1;
    #1;
    z = '0;
    total++;
    if (observe() !== z) begin
      bad++;
      $display("FAIL reset_mid_async got=%h exp=%h", observe(), z);
    end
    @(negedge iCLK);
    total++;
    if (observe() !== z) begin
      bad++;
      $display("FAIL reset_mid_held got=%h exp=%h", observe(), z);
    end
    iRST = 1'b0;
    // Three fetch waits right after reset only pass if the wait count was cleared.
    clear_model();
    model_instr(OP_R, TO - 1, 0, tr);
    run_trace();
    for (int k = 0; k < exp_q.size(); k++) begin
      total++;
      if (obs_q[k] !== exp_q[k]) begin
        bad++;
        $display("FAIL reset_mid_after cyc=%0d got=%h exp=%h", k, obs_q[k], exp_q[k]);
      end
    end
    $display("txn reset_mid_fetch: follow-up cycles=%0d", exp_q.size());
  endtask

  task automatic test_back_to_back();
    bit tr;
    logic [6:0] op;
    int fw, mw, errs;
    for (int n = 0; n < 150; n++) begin
      op = ($urandom_range(0, 11) == 0) ? random_illegal() : legal_ops[$urandom_range(0, 8)];
      fw = ($urandom_range(0, 9) == 0) ? TO + $urandom_range(0, 2) : $urandom_range(0, TO - 1);
      mw = ($urandom_range(0, 9) == 0) ? TO + $urandom_range(0, 2) : $urandom_range(0, TO - 1);
      clear_model();
      model_instr(op, fw, mw, tr);
      run_trace();
      errs = 0;
      for (int k = 0; k < exp_q.size(); k++) begin
        total++;
        if (obs_q[k] !== exp_q[k]) begin
          bad++;
          errs++;
          $display("FAIL b2b n=%0d op=%b cyc=%0d got=%h exp=%h", n, op, k, obs_q[k], exp_q[k]);
        end
      end
      $display("txn b2b n=%0d op=%b fw=%0d mw=%0d cycles=%0d trap=%0d errs=%0d",
               n, op, fw, mw, exp_q.size(), tr, errs);
      if (tr) do_reset();
    end
  endtask

  initial begin
    iRST      = 1'b1;
    iOp       = 7'd0;
    iMemReady = 1'b0;
    test_reset();
    test_add();
    test_lw_wait();
    test_sw_timeout();
    test_illegal();
    test_jalr();
    test_reset_mid_fetch();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
